// File: rtl/mem_writeback.sv
// Memory-access and register-writeback stage of the 8-bit MIPS-subset core.
// Owns the register file and data memory; `define SW_EN to enable the sw store path.
module mem_writeback #(
    parameter int DMEM_AW    = 5,
    parameter int OUTPUT_REG = 2,
    parameter int LINK_REG   = 31
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2:0]         state,
    input  logic [5:0]         opcode,
    input  logic [5:0]         func,
    input  logic [4:0]         rt,
    input  logic [4:0]         rd,
    input  logic [7:0]         rtv,
    input  logic [7:0]         result,
    input  logic               instruction_invalid,
    input  logic [4:0]         rs_rd_addr,
    input  logic [4:0]         rt_rd_addr,
    output logic [7:0]         rs_rd_data,
    output logic [7:0]         rt_rd_data,
    input  logic               ld_we,
    input  logic [DMEM_AW-1:0] ld_addr,
    input  logic [7:0]         ld_data,
    output logic [7:0]         out_value,
    output logic               wb_done,
    output logic [15:0]        retired
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SLT   = 6'h2a;

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_RESULT,
        SEL_MDR
    } wb_sel_t;

    logic [7:0]         regs [32];
    logic [7:0]         dmem [2**DMEM_AW];
    logic [7:0]         mdr;
    logic [4:0]         dest;
    wb_sel_t            wdata_sel;
    logic               pending;

    logic               dec_valid;
    logic               dec_store;
    wb_sel_t            dec_sel;
    logic [4:0]         dec_dest;
    logic [DMEM_AW-1:0] maddr;
    logic               mem_phase;
    logic               wb_phase;
    logic               commit;

    always_comb begin
        dec_valid = 1'b0;
        dec_store = 1'b0;
        dec_sel   = SEL_NONE;
        dec_dest  = '0;
        case (opcode)
            OP_ADDIU: begin dec_valid = 1'b1; dec_sel = SEL_RESULT; dec_dest = rt; end
            OP_LW:    begin dec_valid = 1'b1; dec_sel = SEL_MDR;    dec_dest = rt; end
            OP_JAL:   begin dec_valid = 1'b1; dec_sel = SEL_RESULT; dec_dest = 5'(LINK_REG); end
            OP_BEQ, OP_BNE: dec_valid = 1'b1;
            OP_RTYPE: begin
                if (func == FN_ADDU || func == FN_SLT) begin
                    dec_valid = 1'b1;
                    dec_sel   = SEL_RESULT;
                    dec_dest  = rd;
                end else if (func == FN_JR) begin
                    dec_valid = 1'b1;
                end
            end
`ifdef SW_EN
            OP_SW:    begin dec_valid = 1'b1; dec_store = 1'b1; end
`endif
            default: ;
        endcase
    end

`ifndef SW_EN
    logic [7:0] sw_unused;
    assign sw_unused = rtv;
`endif

    assign maddr     = result[DMEM_AW-1:0];
    assign mem_phase = (state == 3'd4) && !instruction_invalid;
    assign wb_phase  = (state == 3'd5) && !instruction_invalid;
    // pending carries "valid and recognised at state 4" so a squash in either phase blocks commit
    assign commit    = wb_phase && pending;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < 32; i++) regs[i] <= '0;
            for (int unsigned i = 0; i < 2**DMEM_AW; i++) dmem[i] <= '0;
            mdr       <= '0;
            dest      <= '0;
            wdata_sel <= SEL_NONE;
            pending   <= 1'b0;
            wb_done   <= 1'b0;
            retired   <= '0;
        end else begin
            wb_done <= commit;
            if (ld_we) dmem[ld_addr] <= ld_data;
            if (mem_phase) begin
                pending   <= dec_valid;
                dest      <= dec_dest;
                wdata_sel <= dec_sel;
                if (opcode == OP_LW) mdr <= dmem[maddr];
                // later assignment gives the store priority over a same-address loader write
                if (dec_store) dmem[maddr] <= rtv;
            end else if (state == 3'd4 || state == 3'd5) begin
                pending <= 1'b0;
            end
            if (commit) begin
                retired <= retired + 16'd1;
                if (wdata_sel != SEL_NONE && dest != 5'd0)
                    regs[dest] <= (wdata_sel == SEL_MDR) ? mdr : result;
            end
        end
    end

    assign rs_rd_data = (rs_rd_addr == 5'd0) ? '0 : regs[rs_rd_addr];
    assign rt_rd_data = (rt_rd_addr == 5'd0) ? '0 : regs[rt_rd_addr];
    assign out_value  = (OUTPUT_REG == 0) ? '0 : regs[OUTPUT_REG];

endmodule

// File: tb/tb_mem_writeback.sv
// Scoreboard bench for mem_writeback: expectations queued at issue, checked on each wb_done pulse.
module tb_mem_writeback;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  state;
    logic [5:0]  opcode, func;
    logic [4:0]  rt, rd;
    logic [7:0]  rtv, result;
    logic        instruction_invalid;
    logic [4:0]  rs_rd_addr, rt_rd_addr;
    logic [7:0]  rs_rd_data, rt_rd_data;
    logic        ld_we;
    logic [4:0]  ld_addr;
    logic [7:0]  ld_data;
    logic [7:0]  out_value;
    logic        wb_done;
    logic [15:0] retired;

    typedef struct {
        logic [4:0]  addr;
        logic [7:0]  val;
        logic [15:0] ret;
    } exp_t;

    exp_t        sbq[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] exp_ret = '0;

    always #5 clk = ~clk;

    mem_writeback #(.DMEM_AW(5), .OUTPUT_REG(2), .LINK_REG(31)) dut (
        .clk(clk), .rst(rst), .state(state), .opcode(opcode), .func(func),
        .rt(rt), .rd(rd), .rtv(rtv), .result(result),
        .instruction_invalid(instruction_invalid),
        .rs_rd_addr(rs_rd_addr), .rt_rd_addr(rt_rd_addr),
        .rs_rd_data(rs_rd_data), .rt_rd_data(rt_rd_data),
        .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
        .out_value(out_value), .wb_done(wb_done), .retired(retired)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // monitor: every wb_done pulse must match the oldest queued expectation
    always @(negedge clk) begin
        if (wb_done === 1'b1) begin
            if (sbq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_wb_done: got 1 expected 0 (retired=%h)", retired);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check($sformatf("wb_reg%0d", e.addr), {8'h00, rt_rd_data}, {8'h00, e.val});
                check("wb_retired", retired, e.ret);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] t,
                       input logic [4:0] d, input logic [7:0] res, input logic inv4,
                       input logic inv5, input logic commit, input logic [4:0] chk,
                       input logic [7:0] expv);
        state = 3'd4; opcode = op; func = fn; rt = t; rd = d; result = res;
        instruction_invalid = inv4;
        tick();
        state = 3'd5; instruction_invalid = inv5; rt_rd_addr = chk;
        if (commit) begin
            exp_ret = exp_ret + 16'd1;
            sbq.push_back('{addr: chk, val: expv, ret: exp_ret});
        end
        tick();
        state = 3'd0; instruction_invalid = 1'b0;
        tick();
    endtask

    task automatic load(input logic [4:0] a, input logic [7:0] v);
        ld_we = 1'b1; ld_addr = a; ld_data = v;
        tick();
        ld_we = 1'b0;
    endtask

    task automatic check_reset_state();
        for (int i = 0; i < 32; i++) begin
            rs_rd_addr = 5'(i);
            #1;
            check($sformatf("reset_reg%0d", i), {8'h00, rs_rd_data}, 16'h0000);
        end
        check("reset_out_value", {8'h00, out_value}, 16'h0000);
        check("reset_retired", retired, 16'h0000);
        check("reset_wb_done", {15'd0, wb_done}, 16'h0000);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; state = '0; opcode = '0; func = '0; rt = '0; rd = '0; rtv = '0;
        result = '0; instruction_invalid = 1'b0; rs_rd_addr = '0; rt_rd_addr = '0;
        ld_we = 1'b0; ld_addr = '0; ld_data = '0;
        tick(); tick();
        rst = 1'b0;
        check_reset_state();

        // activity, then reset must wipe registers, dmem and counters
        run(6'h09, 6'h00, 5'd5, 5'd0, 8'h33, 1'b0, 1'b0, 1'b1, 5'd5, 8'h33);
        run(6'h09, 6'h00, 5'd2, 5'd0, 8'h66, 1'b0, 1'b0, 1'b1, 5'd2, 8'h66);
        load(5'd9, 8'h44);
        rst = 1'b1; tick(); rst = 1'b0;
        exp_ret = '0;
        check_reset_state();
        run(6'h23, 6'h00, 5'd6, 5'd0, 8'h09, 1'b0, 1'b0, 1'b1, 5'd6, 8'h00);

        // addiu to the output register
        run(6'h09, 6'h00, 5'd2, 5'd0, 8'h2A, 1'b0, 1'b0, 1'b1, 5'd2, 8'h2A);
        check("addiu_out_value", {8'h00, out_value}, 16'h002A);

        // lw with address wrap 0x25 -> 5
        load(5'd5, 8'h77);
        run(6'h23, 6'h00, 5'd3, 5'd0, 8'h25, 1'b0, 1'b0, 1'b1, 5'd3, 8'h77);

        // jal to link reg, addu to $0, slt, beq, jr
        run(6'h03, 6'h00, 5'd0, 5'd0, 8'h0D, 1'b0, 1'b0, 1'b1, 5'd31, 8'h0D);
        run(6'h00, 6'h21, 5'd0, 5'd0, 8'hFF, 1'b0, 1'b0, 1'b1, 5'd0, 8'h00);
        run(6'h00, 6'h2a, 5'd0, 5'd7, 8'h01, 1'b0, 1'b0, 1'b1, 5'd7, 8'h01);
        run(6'h04, 6'h00, 5'd2, 5'd2, 8'h99, 1'b0, 1'b0, 1'b1, 5'd2, 8'h2A);
        run(6'h00, 6'h08, 5'd3, 5'd3, 8'h88, 1'b0, 1'b0, 1'b1, 5'd3, 8'h77);

        // squashes: invalid at state 5, invalid at state 4, unknown opcode
        run(6'h00, 6'h21, 5'd0, 5'd4, 8'h11, 1'b0, 1'b1, 1'b0, 5'd4, 8'h00);
        run(6'h09, 6'h00, 5'd4, 5'd0, 8'h12, 1'b1, 1'b0, 1'b0, 5'd4, 8'h00);
        run(6'h3F, 6'h00, 5'd4, 5'd4, 8'h13, 1'b0, 1'b0, 1'b0, 5'd4, 8'h00);
        rs_rd_addr = 5'd4; #1;
        check("squash_reg4", {8'h00, rs_rd_data}, 16'h0000);
        check("squash_retired", retired, 16'd8);

        // reset asserted during writeback discards the instruction
        state = 3'd4; opcode = 6'h09; rt = 5'd4; result = 8'h55;
        tick();
        state = 3'd5; rst = 1'b1;
        tick();
        rst = 1'b0; state = 3'd0;
        exp_ret = '0;
        tick();
        rs_rd_addr = 5'd4; #1;
        check("rst_wb_reg4", {8'h00, rs_rd_data}, 16'h0000);
        check("rst_wb_retired", retired, 16'h0000);

        // sw colliding with a same-cycle loader write to address 7
        state = 3'd4; opcode = 6'h2b; func = 6'h00; result = 8'h07; rtv = 8'h5C;
        ld_we = 1'b1; ld_addr = 5'd7; ld_data = 8'hAA;
        tick();
        ld_we = 1'b0; state = 3'd5; rt_rd_addr = 5'd0;
`ifdef SW_EN
        exp_ret = exp_ret + 16'd1;
        sbq.push_back('{addr: 5'd0, val: 8'h00, ret: exp_ret});
`endif
        tick();
        state = 3'd0;
        tick();
`ifdef SW_EN
        run(6'h23, 6'h00, 5'd8, 5'd0, 8'h07, 1'b0, 1'b0, 1'b1, 5'd8, 8'h5C);
        check("sw_retired", retired, 16'd2);
`else
        run(6'h23, 6'h00, 5'd8, 5'd0, 8'h07, 1'b0, 1'b0, 1'b1, 5'd8, 8'hAA);
        check("sw_retired", retired, 16'd1);
`endif

        tick(); tick();
        check("scoreboard_drained", 16'(sbq.size()), 16'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
